// File: rtl/nwc_processor_core.sv
// Negacyclic convolution engine: c = a*b mod (x^N + 1) mod q with P parallel MAC lanes.
// Operands load as packed coefficient pairs; the result streams out as N/2 packed words.
module nwc_processor_core #(
    parameter int MOD_INDEX      = 0,
    parameter int LOG_CORE_COUNT = 3,
    parameter int LOG_N          = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [59:0] data_in0,
    input  logic [59:0] data_in1,
    input  logic        write_enable,
    input  logic        start,
    output logic [59:0] data_out,
    output logic        output_active
);

    localparam int N = 1 << LOG_N;
    localparam int P = 1 << LOG_CORE_COUNT;
    localparam logic [29:0] Q  = (MOD_INDEX == 1) ? 30'h3FF8_0001 : 30'h3FFC_0001;
    localparam logic [30:0] MU = 31'((64'd1 << 60) / {34'd0, Q});
    localparam logic [31:0] Q1 = {2'b00, Q};
    localparam logic [31:0] Q2 = {1'b0, Q, 1'b0};
    localparam logic [LOG_N-1:0] STEP_P_LAST = LOG_N'(P - 1);
    localparam logic [LOG_N-1:0] KB_LAST     = LOG_N'(N - P);
    localparam logic [LOG_N-1:0] KB_INC      = LOG_N'(P);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_MAC, S_DRAIN, S_OUTPUT} state_t;

    // Barrett reduction of a 60-bit product; the estimate is at most 2 low, so r < 3q.
    function automatic logic [29:0] mod_reduce(input logic [59:0] p);
        logic [30:0] qhat;
        logic [31:0] r;
        qhat = 31'(({31'd0, p[59:29]} * {31'd0, MU}) >> 31);
        r    = p[31:0] - ({1'b0, qhat} * Q1);
        if (r >= Q2) r = r - Q2;
        if (r >= Q1) r = r - Q1;
        return 30'(r);
    endfunction

    function automatic logic [29:0] mod_add(input logic [29:0] x, input logic [29:0] y);
        logic [30:0] s;
        // NOTE: blocking '=' is correct here: s is a temporary inside combinational code,
        // each assignment must be visible to the next statement.
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return 30'(s);
    endfunction

    function automatic logic [29:0] reduce_in(input logic [29:0] x);
        return (x >= Q) ? x - Q : x;
    endfunction

    state_t             r_state;
    logic [LOG_N-2:0]   r_load_cnt;
    logic [LOG_N-2:0]   r_out_cnt;
    logic [LOG_N-1:0]   r_step;
    logic [LOG_N-1:0]   r_kb;
    logic               r_v1;
    logic               r_v2;
    logic               r_out_active;

    logic [29:0] r_a_mem [N];
    logic [29:0] r_b_mem [N];
    logic [29:0] r_c_mem [N];

    logic [29:0] r_win_val  [P];
    logic        r_win_neg  [P];
    logic [59:0] r_prod     [P];
    logic        r_prod_neg [P];
    logic [29:0] r_red      [P];
    logic        r_red_neg  [P];
    logic [29:0] r_acc      [P];

    logic             w_load;
    logic             w_drain_done;
    logic [LOG_N-1:0] w_b_idx;
    logic [29:0]      w_a_coef;
    logic [29:0]      w_b_coef;
    logic             w_b_neg;

    assign w_load       = (r_state == S_IDLE) && write_enable;
    assign w_drain_done = (r_state == S_DRAIN) && !r_v1 && !r_v2;

    // Priming fills the window highest index first so lane l ends up holding b[kb+l];
    // during MAC the next entry is b[kb-i-1], wrapped (and negated) once i >= kb.
    assign w_b_idx  = (r_state == S_PRIME) ? r_kb + STEP_P_LAST - r_step : r_kb - r_step - 1'b1;
    assign w_a_coef = r_a_mem[r_step];
    assign w_b_coef = r_b_mem[w_b_idx];
    assign w_b_neg  = (r_state == S_MAC) && (r_step >= r_kb);

    assign output_active = r_out_active;
    assign data_out      = r_out_active ? {r_c_mem[{r_out_cnt, 1'b1}], r_c_mem[{r_out_cnt, 1'b0}]} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_load_cnt   <= '0;
            r_out_cnt    <= '0;
            r_step       <= '0;
            r_kb         <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_out_active <= 1'b0;
        end else begin
            r_v1       <= (r_state == S_MAC);
            r_v2       <= r_v1;
            r_load_cnt <= w_load ? r_load_cnt + 1'b1 : '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_PRIME;
                        r_kb    <= '0;
                        r_step  <= '0;
                    end
                end
                S_PRIME: begin
                    r_step <= (r_step == STEP_P_LAST) ? '0 : r_step + 1'b1;
                    if (r_step == STEP_P_LAST) r_state <= S_MAC;
                end
                S_MAC: begin
                    r_step <= r_step + 1'b1;
                    if (r_step == '1) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        if (r_kb == KB_LAST) begin
                            r_state      <= S_OUTPUT;
                            r_out_active <= 1'b1;
                            r_out_cnt    <= '0;
                        end else begin
                            r_state <= S_PRIME;
                            r_kb    <= r_kb + KB_INC;
                        end
                    end
                end
                S_OUTPUT: begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                    if (r_out_cnt == '1) begin
                        r_state      <= S_IDLE;
                        r_out_active <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: storage and datapath registers carry no reset: their contents are always
    // written before being used, and coefficient storage must survive a reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_a_mem[{r_load_cnt, 1'b0}] <= reduce_in(data_in0[29:0]);
            r_a_mem[{r_load_cnt, 1'b1}] <= reduce_in(data_in0[59:30]);
            r_b_mem[{r_load_cnt, 1'b0}] <= reduce_in(data_in1[29:0]);
            r_b_mem[{r_load_cnt, 1'b1}] <= reduce_in(data_in1[59:30]);
        end
        if (r_state == S_PRIME || r_state == S_MAC) begin
            for (int l = P - 1; l > 0; l--) begin
                r_win_val[l] <= r_win_val[l-1];
                r_win_neg[l] <= r_win_neg[l-1];
            end
            r_win_val[0] <= w_b_coef;
            r_win_neg[0] <= w_b_neg;
        end
        for (int l = 0; l < P; l++) begin
            if (r_state == S_MAC) begin
                r_prod[l]     <= {30'd0, w_a_coef} * {30'd0, r_win_val[l]};
                r_prod_neg[l] <= r_win_neg[l];
            end
            r_red[l]     <= mod_reduce(r_prod[l]);
            r_red_neg[l] <= r_prod_neg[l];
            if (r_state == S_PRIME) begin
                r_acc[l] <= '0;
            end else if (r_v2) begin
                r_acc[l] <= mod_add(r_acc[l], (r_red_neg[l] && r_red[l] != '0) ? Q - r_red[l]
                                                                                 : (r_red_neg[l] ? '0 : r_red[l]));
            end
            if (w_drain_done) r_c_mem[r_kb + LOG_N'(l)] <= r_acc[l];
        end
    end

endmodule

// File: tb/tb_nwc_processor_core.sv
// Scoreboard bench: two lockstep N=16/P=8 cores (both moduli) and one N=64/P=4 core,
// checked against a direct negacyclic convolution reference.
module tb_nwc_processor_core;

    localparam int NA = 16;
    localparam int NB = 64;
    localparam longint unsigned Q0 = 64'h3FFC_0001;
    localparam longint unsigned Q1 = 64'h3FF8_0001;
    localparam int BOUND_A = (NA / 8) * (NA + 8 + 16);
    localparam int BOUND_B = (NB / 4) * (NB + 4 + 16);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [59:0] a_din0, a_din1, b_din0, b_din1;
    logic        a_we, a_start, b_we, b_start;
    logic [59:0] a0_dout, a1_dout, b_dout;
    logic        a0_act, a1_act, b_act;

    nwc_processor_core #(.MOD_INDEX(0), .LOG_CORE_COUNT(3), .LOG_N(4)) dut_a0 (
        .clk(clk), .rst_n(rst_n), .data_in0(a_din0), .data_in1(a_din1),
        .write_enable(a_we), .start(a_start), .data_out(a0_dout), .output_active(a0_act));

    nwc_processor_core #(.MOD_INDEX(1), .LOG_CORE_COUNT(3), .LOG_N(4)) dut_a1 (
        .clk(clk), .rst_n(rst_n), .data_in0(a_din0), .data_in1(a_din1),
        .write_enable(a_we), .start(a_start), .data_out(a1_dout), .output_active(a1_act));

    nwc_processor_core #(.MOD_INDEX(0), .LOG_CORE_COUNT(2), .LOG_N(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in0(b_din0), .data_in1(b_din1),
        .write_enable(b_we), .start(b_start), .data_out(b_dout), .output_active(b_act));

    int n_checks = 0;
    int n_errors = 0;

    logic [59:0] qa0[$];
    logic [59:0] qa1[$];
    logic [59:0] qb[$];
    logic [29:0] ma[64];
    logic [29:0] mb[64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_coef(int n, longint unsigned q, int k);
        longint unsigned acc = 0;
        longint unsigned x, y, p;
        for (int i = 0; i < n; i++) begin
            x = {34'd0, ma[i]} % q;
            y = {34'd0, mb[(k - i + n) % n]} % q;
            p = (x * y) % q;
            if (i <= k) acc = (acc + p) % q;
            else        acc = (acc + q - p) % q;
        end
        return acc;
    endfunction

    function automatic logic [59:0] ref_word(int n, longint unsigned q, int w);
        logic [29:0] lo, hi;
        lo = 30'(ref_coef(n, q, 2 * w));
        hi = 30'(ref_coef(n, q, 2 * w + 1));
        return {hi, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit grp_b, input int words);
        for (int w = 0; w < words; w++) begin
            if (grp_b) begin
                b_din0 = {ma[2*w+1], ma[2*w]};
                b_din1 = {mb[2*w+1], mb[2*w]};
                b_we   = 1'b1;
            end else begin
                a_din0 = {ma[2*w+1], ma[2*w]};
                a_din1 = {mb[2*w+1], mb[2*w]};
                a_we   = 1'b1;
            end
            tick();
        end
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic clear_operands();
        for (int i = 0; i < 64; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
    endtask

    task automatic run_a(input string tag, input bit disturb, output int lat);
        int cnt;
        logic [59:0] exp0, exp1;
        for (int w = 0; w < NA / 2; w++) begin
            qa0.push_back(ref_word(NA, Q0, w));
            qa1.push_back(ref_word(NA, Q1, w));
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        lat = 0;
        while (!a0_act && lat < BOUND_A) begin
            if (disturb && lat == 2) a_start = 1'b1;
            tick();
            a_start = 1'b0;
            lat++;
        end
        check({tag, " act_rise"}, 64'(a0_act), 64'd1);
        check({tag, " lat_le_bound"}, 64'(lat <= BOUND_A), 64'd1);
        cnt = 0;
        while (a0_act && cnt < NA / 2 + 4) begin
            exp0 = (qa0.size() != 0) ? qa0.pop_front() : 'x;
            exp1 = (qa1.size() != 0) ? qa1.pop_front() : 'x;
            check($sformatf("%s q0_word%0d", tag, cnt), 64'(a0_dout), 64'(exp0));
            check($sformatf("%s q1_act%0d", tag, cnt), 64'(a1_act), 64'd1);
            check($sformatf("%s q1_word%0d", tag, cnt), 64'(a1_dout), 64'(exp1));
            if (disturb && cnt == 2) begin
                a_we   = 1'b1;
                a_din0 = {30'($urandom), 30'($urandom)};
                a_din1 = {30'($urandom), 30'($urandom)};
            end
            tick();
            a_we = 1'b0;
            cnt++;
        end
        check({tag, " burst_len"}, 64'(cnt), 64'(NA / 2));
        check({tag, " sb_empty_q0"}, 64'(qa0.size()), 64'd0);
        check({tag, " sb_empty_q1"}, 64'(qa1.size()), 64'd0);
        check({tag, " idle_dout_q0"}, 64'(a0_dout), 64'd0);
        check({tag, " idle_act_q1"}, 64'(a1_act), 64'd0);
        qa0.delete();
        qa1.delete();
    endtask

    task automatic run_b(input string tag, input int rst_at);
        int lat, cnt;
        bit aborted;
        logic [59:0] exp;
        for (int w = 0; w < NB / 2; w++) qb.push_back(ref_word(NB, Q0, w));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        lat = 0;
        while (!b_act && lat < BOUND_B) begin
            tick();
            lat++;
        end
        check({tag, " act_rise"}, 64'(b_act), 64'd1);
        check({tag, " lat_le_bound"}, 64'(lat <= BOUND_B), 64'd1);
        cnt = 0;
        aborted = 1'b0;
        while (b_act && cnt < NB / 2 + 4 && !aborted) begin
            exp = (qb.size() != 0) ? qb.pop_front() : 'x;
            check($sformatf("%s word%0d", tag, cnt), 64'(b_dout), 64'(exp));
            if (cnt == rst_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " act_in_reset"}, 64'(b_act), 64'd0);
                check({tag, " dout_in_reset"}, 64'(b_dout), 64'd0);
                aborted = 1'b1;
            end else begin
                tick();
                cnt++;
            end
        end
        if (aborted) begin
            qb.delete();
            tick();
            rst_n = 1'b1;
            tick();
            check({tag, " idle_after_reset"}, 64'(b_act), 64'd0);
        end else begin
            check({tag, " burst_len"}, 64'(cnt), 64'(NB / 2));
            check({tag, " sb_empty"}, 64'(qb.size()), 64'd0);
            check({tag, " idle_dout"}, 64'(b_dout), 64'd0);
        end
        qb.delete();
    endtask

    initial begin
        int base_lat, lat;
        a_din0 = '0; a_din1 = '0; a_we = 1'b0; a_start = 1'b0;
        b_din0 = '0; b_din1 = '0; b_we = 1'b0; b_start = 1'b0;
        repeat (3) tick();
        check("reset act_a0", 64'(a0_act), 64'd0);
        check("reset dout_a1", 64'(a1_dout), 64'd0);
        check("reset dout_b", 64'(b_dout), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset act_a1", 64'(a1_act), 64'd0);
        check("post_reset act_b", 64'(b_act), 64'd0);
        check("post_reset dout_a0", 64'(a0_dout), 64'd0);

        // a = 1: the product must reproduce b unchanged
        clear_operands();
        ma[0] = 30'd1;
        for (int i = 0; i < NA; i++) mb[i] = 30'($urandom_range(0, 32'(Q1 - 1)));
        load(1'b0, NA / 2);
        run_a("unit_a", 1'b0, base_lat);

        // x * x^15 wraps once: coefficient 0 becomes -1
        clear_operands();
        ma[1]  = 30'd1;
        mb[15] = 30'd1;
        load(1'b0, NA / 2);
        run_a("neg_wrap", 1'b0, lat);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NA; i++) begin
                ma[i] = 30'($urandom);
                mb[i] = 30'($urandom);
            end
            load(1'b0, NA / 2);
            run_a($sformatf("rand%0d", r), 1'b0, lat);
        end

        // coefficient above q must be reduced on store
        clear_operands();
        ma[0] = 30'h3FFF_FFFF;
        mb[0] = 30'd1;
        load(1'b0, NA / 2);
        run_a("over_q", 1'b0, lat);

        for (int i = 0; i < NA; i++) begin
            ma[i] = 30'($urandom);
            mb[i] = 30'($urandom);
        end
        load(1'b0, NA / 2);
        run_a("disturb", 1'b1, lat);
        check("disturb start_ignored_latency", 64'(lat), 64'(base_lat));
        run_a("rerun", 1'b0, lat);

        for (int i = 0; i < NB; i++) begin
            ma[i] = 30'($urandom);
            mb[i] = 30'($urandom);
        end
        load(1'b1, NB / 2);
        run_b("big", -1);
        run_b("rst_mid", 5);
        run_b("after_rst", -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
